// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
//
// Output stage for the sign-magnitude add/sub unit. A load strobe captures the
// 5-bit result and the zero flag. The captured value is shown on a two-digit,
// time-multiplexed seven-segment display: digit0 is the hex magnitude and
// digit1 is the sign.
//
// Optional feature macro: ZERO_BLINK_EN
//   When it is defined, a held zero result blinks. The blink phase toggles
//   every BLINK_DIV digit slots.
//   When it is undefined, a zero result is displayed steadily.
//
// Parameters
//   REFRESH_DIV : clock cycles per digit slot (>= 2)
//   BLINK_DIV   : digit slots per blink half-period (ZERO_BLINK_EN only)
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous reset, active high
//   result   in   5  bit4 = sign (1 = negative), bits3:0 = magnitude
//   zeroflag in   1  zero flag from add/sub, sampled with result
//   load     in   1  capture strobe
//   clr      in   1  synchronous clear back to EMPTY (wins over load)
//   seg      out  7  segments {g,f,e,d,c,b,a}, active low, registered
//   an       out  4  digit enables, active low, registered; an[3:2] stay 1
//   valid    out  1  high while a captured result is held
//   zero_led out  1  captured zero flag
// -----------------------------------------------------------------------------
module result_display #(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] result,
    input  logic       zeroflag,
    input  logic       load,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       valid,
    output logic       zero_led
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam int             RW      = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0]  REF_MAX = RW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_DIG0   = 4'b1110;
    localparam logic [3:0] AN_DIG1   = 4'b1101;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_hex_glyph(input logic [3:0] i_val);
        logic [6:0] v_seg;
        case (i_val)
            4'h0:    v_seg = 7'b1000000;
            4'h1:    v_seg = 7'b1111001;
            4'h2:    v_seg = 7'b0100100;
            4'h3:    v_seg = 7'b0110000;
            4'h4:    v_seg = 7'b0011001;
            4'h5:    v_seg = 7'b0010010;
            4'h6:    v_seg = 7'b0000010;
            4'h7:    v_seg = 7'b1111000;
            4'h8:    v_seg = 7'b0000000;
            4'h9:    v_seg = 7'b0010000;
            4'hA:    v_seg = 7'b0001000;
            4'hB:    v_seg = 7'b0000011;
            4'hC:    v_seg = 7'b1000110;
            4'hD:    v_seg = 7'b0100001;
            4'hE:    v_seg = 7'b0000110;
            4'hF:    v_seg = 7'b0001110;
            default: v_seg = SEG_BLANK;
        endcase
        return v_seg;
    endfunction

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_mag;
    logic          r_neg;
    logic          r_zero;
    logic [RW-1:0] r_refresh_cnt;
    logic          r_sel;
    logic          w_wrap;
    logic          w_blank;
    logic [6:0]    w_digit0;
    logic [6:0]    w_digit1;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_an_next;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    assign w_wrap = (r_refresh_cnt == REF_MAX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: clr wins over load, load from any state recaptures
    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_EMPTY;
        end else if (load) begin
            w_state_next = ST_SHOW;
        end else begin
            w_state_next = r_state;
        end
    end

    // Captured result; clr returns it to the reset value along with EMPTY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag  <= 4'd0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
        end else if (clr) begin
            r_mag  <= 4'd0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
        end else if (load) begin
            r_mag  <= result[3:0];
            r_neg  <= result[4];
            r_zero <= zeroflag;
        end else begin
            r_mag  <= r_mag;
            r_neg  <= r_neg;
            r_zero <= r_zero;
        end
    end

    // Refresh counter and digit select; free-running, unaffected by load/clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_sel         <= 1'b0;
        end else if (w_wrap) begin
            r_refresh_cnt <= '0;
            r_sel         <= ~r_sel;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RW'(1);
            r_sel         <= r_sel;
        end
    end

`ifdef ZERO_BLINK_EN
    localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;

    // Blink counter: counts slot wraps and restarts in the "off" phase on every load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else if (load) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == BLINK_MAX) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
                r_blink_on  <= r_blink_on;
            end
        end else begin
            r_blink_cnt <= r_blink_cnt;
            r_blink_on  <= r_blink_on;
        end
    end

    assign w_blank = r_zero & ~r_blink_on;
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_DIV > 0);
    assign w_blank        = 1'b0;
`endif

    // Glyph selection for the current slot; registered below for the pins
    always_comb begin
        w_digit0   = SEG_DASH;
        w_digit1   = SEG_BLANK;
        w_seg_next = SEG_BLANK;
        w_an_next  = AN_DIG0;
        if (r_state == ST_SHOW) begin
            if (w_blank) begin
                w_digit0 = SEG_BLANK;
                w_digit1 = SEG_BLANK;
            end else begin
                w_digit0 = f_hex_glyph(r_mag);
                // Negative zero is shown as plain "0", without a sign
                if (r_neg && (r_mag != 4'd0)) begin
                    w_digit1 = SEG_DASH;
                end else begin
                    w_digit1 = SEG_BLANK;
                end
            end
        end else begin
            w_digit0 = SEG_DASH;
            w_digit1 = SEG_BLANK;
        end
        if (r_sel) begin
            w_seg_next = w_digit1;
            w_an_next  = AN_DIG1;
        end else begin
            w_seg_next = w_digit0;
            w_an_next  = AN_DIG0;
        end
    end

    // Registered display pins; all segments and digits are off in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign valid    = (r_state == ST_SHOW);
    assign zero_led = r_zero;

endmodule

// File: tb/tb_result_display.sv
// -----------------------------------------------------------------------------
// tb_result_display
//
// Self-checking bench for result_display, with REFRESH_DIV=4 and BLINK_DIV=2.
// The reference model works from edge numbers. After the n-th edge following
// reset release, the expected digit is (n / REFRESH_DIV) % 2. The blink phase
// comes from the number of slot wraps seen since the last load.
// -----------------------------------------------------------------------------
module tb_result_display;

    localparam int RD = 4;
    localparam int BD = 2;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [4:0] result   = 5'd0;
    logic       zeroflag = 1'b0;
    logic       load     = 1'b0;
    logic       clr      = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       valid;
    logic       zero_led;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         n;
    bit         m_show;
    bit [3:0]   m_mag;
    bit         m_neg;
    bit         m_zero;
    int         m_load_edge;

    always #5 clk = ~clk;

    result_display #(
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .zeroflag (zeroflag),
        .load     (load),
        .clr      (clr),
        .seg      (seg),
        .an       (an),
        .valid    (valid),
        .zero_led (zero_led)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Expected pins after edge n, based on the model state just before that edge
    task automatic expect_pins(output logic [6:0] es, output logic [3:0] ea);
        int  sel;
        bit  blank;
        sel   = (n / RD) % 2;
        ea    = (sel == 1) ? 4'b1101 : 4'b1110;
        blank = 1'b0;
        if (!m_show) begin
            es = (sel == 1) ? BLANK : DASH;
        end else begin
`ifdef ZERO_BLINK_EN
            begin
                int k;
                k = (n / RD) - ((m_load_edge + 1) / RD);
                if (m_zero && (((k / BD) % 2) == 0)) blank = 1'b1;
            end
`endif
            if (blank)         es = BLANK;
            else if (sel == 0) es = exp_glyph(m_mag);
            else               es = (m_neg && (m_mag != 4'd0)) ? DASH : BLANK;
        end
    endtask

    task automatic cycle(input logic ld, input logic cl, input logic [4:0] res, input logic zf);
        logic [6:0] es;
        logic [3:0] ea;
        load     = ld;
        clr      = cl;
        result   = res;
        zeroflag = zf;
        expect_pins(es, ea);
        @(posedge clk);
        if (cl) begin
            m_show = 1'b0; m_mag = 4'd0; m_neg = 1'b0; m_zero = 1'b0;
        end else if (ld) begin
            m_show = 1'b1; m_mag = res[3:0]; m_neg = res[4]; m_zero = zf;
            m_load_edge = n;
        end
        n++;
        #1;
        check_eq("an", 32'(an), 32'(ea));
        check_eq("seg", 32'(seg), 32'(es));
        check_eq("valid", 32'(valid), 32'(m_show));
        check_eq("zero_led", 32'(zero_led), 32'(m_zero));
        load = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Assert reset between edges, check the async effect, then release before an edge
    task automatic apply_reset();
        rst = 1'b1;
        #2;
        check_eq("rst_seg", 32'(seg), 32'(BLANK));
        check_eq("rst_an", 32'(an), 32'h0000000f);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_zero_led", 32'(zero_led), 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_an", 32'(an), 32'h0000000f);
        rst         = 1'b0;
        n           = 0;
        m_show      = 1'b0;
        m_mag       = 4'd0;
        m_neg       = 1'b0;
        m_zero      = 1'b0;
        m_load_edge = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        apply_reset();

        // EMPTY scanning
        idle(10);
        // Negative three: digit0 '3', digit1 '-'
        cycle(1'b1, 1'b0, 5'b10011, 1'b0);
        idle(10);
        // Negative zero with the zero flag: digit0 '0', no sign, possible blink
        cycle(1'b1, 1'b0, 5'b10000, 1'b1);
        idle(40);
        // Load and clr on the same edge: clr wins
        cycle(1'b1, 1'b1, 5'b00101, 1'b0);
        idle(10);
        // Back-to-back loads: the last one wins
        cycle(1'b1, 1'b0, 5'b00001, 1'b0);
        cycle(1'b1, 1'b0, 5'b11010, 1'b0);
        idle(10);
        // Load on a wrap edge
        while ((n % RD) != (RD - 1)) idle(1);
        cycle(1'b1, 1'b0, 5'b00000, 1'b1);
        idle(20);

        // Randomized traffic, including a reset in the middle of the run
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] r;
            logic       ld;
            logic       cl;
            if (i == 700) apply_reset();
            r  = 5'($urandom_range(0, 31));
            ld = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 31) == 0);
            cycle(ld, cl, r, (r[3:0] == 4'd0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
